// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential adder/subtractor.
//   state_t : controller states (IDLE -> RUN -> DONE -> IDLE)
//   OP_ADD  : op encoding for A + B + Ci
//   OP_SUB  : op encoding for A - B (carry-in ignored)
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_seq_if.sv
// Request/result bundle for addsub_seq.
//   start, op, A, B, Ci : request side, driven by the master
//   ready, done         : handshake status, driven by the slave
//   S, Co, overflow,
//   zero, negative      : registered result and flags, driven by the slave
interface addsub_seq_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output start, op, A, B, Ci,
    input  ready, done, S, Co, overflow, zero, negative
  );

  modport slave (
    input  start, op, A, B, Ci,
    output ready, done, S, Co, overflow, zero, negative
  );

endinterface

// File: rtl/addsub_seq_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice.
//   a_i, b_i : chunk operands
//   ci_i     : carry into bit 0
//   s_o      : chunk sum
//   co_o     : carry out of the chunk MSB
//   cmsb_o   : carry into the chunk MSB (for signed overflow on the top chunk)
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = ci_i;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  always_comb begin
    co_o   = c[CHUNK];
    cmsb_o = c[CHUNK-1];
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor, CHUNK bits per clock, N = WIDTH/CHUNK cycles.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of addsub_seq_if (start/op/A/B/Ci in; ready/done,
//           result S and flags Co/overflow/zero/negative out)
// Subtraction is done as A + ~B + 1; Co=1 then means "no borrow".
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic         clk,
  input logic         rst_n,
  addsub_seq_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;

  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic             accept;
  logic             last;
  int unsigned      sh;
  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_co, chunk_cmsb;

  always_comb begin
    accept = (state_q == IDLE) && bus.start;
    last   = (state_q == RUN) && (k_q == KW'(N - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake and result outputs
  always_comb begin
    bus.ready    = (state_q == IDLE);
    bus.done     = (state_q == DONE);
    bus.S        = s_q;
    bus.Co       = co_q;
    bus.overflow = ov_q;
    bus.zero     = zero_q;
    bus.negative = neg_q;
  end

  // Chunk k is selected by shifting rather than a variable part-select, which
  // keeps the slice in range even when N=1.
  always_comb begin
    sh      = 32'(k_q) * 32'(CHUNK);
    chunk_a = CHUNK'(a_q >> sh);
    chunk_b = CHUNK'(b_q >> sh);
  end

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i    (chunk_a),
    .b_i    (chunk_b),
    .ci_i   (c_q),
    .s_o    (chunk_s),
    .co_o   (chunk_co),
    .cmsb_o (chunk_cmsb)
  );

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    k_d    = k_q;
    sum_d  = sum_q;
    s_d    = s_q;
    co_d   = co_q;
    ov_d   = ov_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    if (accept) begin
      a_d   = bus.A;
      b_d   = (bus.op == OP_SUB) ? ~bus.B : bus.B;
      c_d   = (bus.op == OP_SUB) ? 1'b1 : bus.Ci;
      k_d   = '0;
      sum_d = '0;
    end else if (state_q == RUN) begin
      // sum is cleared on accept, so each chunk can simply be OR-ed into place
      sum_d = sum_q | (WIDTH'(chunk_s) << sh);
      c_d   = chunk_co;
      k_d   = last ? '0 : k_q + KW'(1);
      if (last) begin
        s_d    = sum_d;
        co_d   = chunk_co;
        ov_d   = chunk_cmsb ^ chunk_co;
        zero_d = (sum_d == '0);
        neg_d  = sum_d[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      k_q    <= '0;
      sum_q  <= '0;
      s_q    <= '0;
      co_q   <= 1'b0;
      ov_q   <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      k_q    <= k_d;
      sum_q  <= sum_d;
      s_q    <= s_d;
      co_q   <= co_d;
      ov_q   <= ov_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: an 8-bit/4-bit-chunk instance for the
// hand-computed vectors, plus a 16-bit/1-bit-chunk instance streamed against
// a behavioural model with start held high.
module tb_addsub_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  addsub_seq_if #(.WIDTH(8))  b8  ();
  addsub_seq_if #(.WIDTH(16)) b16 ();

  addsub_seq #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  addsub_seq #(.WIDTH(16), .CHUNK(1)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  // Directed vectors: op, A, B, Ci, expected S, expected {Co,overflow,zero,negative}
  logic       v_op [7] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
  logic [7:0] v_a  [7] = '{8'h7F, 8'hFF, 8'h05, 8'h80, 8'h00, 8'h12, 8'h10};
  logic [7:0] v_b  [7] = '{8'h01, 8'h00, 8'h05, 8'h01, 8'h01, 8'h34, 8'h01};
  logic       v_ci [7] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
  logic [7:0] v_s  [7] = '{8'h80, 8'h00, 8'h00, 8'h7F, 8'hFF, 8'h47, 8'h0F};
  logic [3:0] v_f  [7] = '{4'b0101, 4'b1010, 4'b1010, 4'b1100, 4'b0001, 4'b0000, 4'b1000};

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (b8.ready !== 1'b1 || b8.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: ready=%b done=%b, want ready=1 done=0", b8.ready, b8.done);
    end
    total++;
    if ({b8.S, b8.Co, b8.overflow, b8.zero, b8.negative} !== 12'h000) begin
      bad++;
      $display("FAIL reset_out: S=%h flags=%b%b%b%b, want all 0",
               b8.S, b8.Co, b8.overflow, b8.zero, b8.negative);
    end
    total++;
    if (b16.ready !== 1'b1 || b16.S !== 16'h0000) begin
      bad++;
      $display("FAIL reset_wide: ready=%b S=%h, want ready=1 S=0000", b16.ready, b16.S);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arith();
    int cyc;
    for (int i = 0; i < 7; i++) begin
      b8.op    = v_op[i];
      b8.A     = v_a[i];
      b8.B     = v_b[i];
      b8.Ci    = v_ci[i];
      b8.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b8.start = 1'b0;
      total++;
      if (b8.ready !== 1'b0) begin
        bad++;
        $display("FAIL arith%0d_ready_low: ready=%b, want 0", i, b8.ready);
      end
      cyc = 0;
      while (b8.done !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      total++;
      if (cyc !== 2) begin
        bad++;
        $display("FAIL arith%0d_latency: got %0d cycles, want 2", i, cyc);
      end
      total++;
      if (b8.S !== v_s[i]) begin
        bad++;
        $display("FAIL arith%0d_S: got %h, want %h", i, b8.S, v_s[i]);
      end
      total++;
      if ({b8.Co, b8.overflow, b8.zero, b8.negative} !== v_f[i]) begin
        bad++;
        $display("FAIL arith%0d_flags: got %b, want %b", i,
                 {b8.Co, b8.overflow, b8.zero, b8.negative}, v_f[i]);
      end
      @(negedge clk);
      total++;
      if (b8.done !== 1'b0 || b8.ready !== 1'b1) begin
        bad++;
        $display("FAIL arith%0d_after: done=%b ready=%b, want done=0 ready=1", i, b8.done, b8.ready);
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (b8.S !== 8'h0F) begin
      bad++;
      $display("FAIL hold_S: got %h, want 0f", b8.S);
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    b8.op    = 1'b0;
    b8.A     = 8'h10;
    b8.B     = 8'h20;
    b8.Ci    = 1'b0;
    b8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // new operands and start held high through RUN and DONE
    b8.op = 1'b1;
    b8.A  = 8'hFF;
    b8.B  = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b8.done === 1'b1) begin
        dones++;
        b8.start = 1'b0;
      end
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL ignore_dones: got %0d pulses, want 1", dones);
    end
    total++;
    if (b8.S !== 8'h30 || {b8.Co, b8.overflow, b8.zero, b8.negative} !== 4'b0000) begin
      bad++;
      $display("FAIL ignore_result: S=%h flags=%b, want S=30 flags=0000",
               b8.S, {b8.Co, b8.overflow, b8.zero, b8.negative});
    end
    total++;
    if (b8.ready !== 1'b1) begin
      bad++;
      $display("FAIL ignore_ready: got %b, want 1", b8.ready);
    end
  endtask

  task automatic test_reset_midrun();
    int dones = 0;
    int cyc;
    b8.op    = 1'b0;
    b8.A     = 8'h55;
    b8.B     = 8'h11;
    b8.Ci    = 1'b0;
    b8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b8.start = 1'b0;
    rst_n    = 1'b0;
    #1;
    total++;
    if (b8.ready !== 1'b1 || b8.done !== 1'b0 || b8.S !== 8'h00 ||
        {b8.Co, b8.overflow, b8.zero, b8.negative} !== 4'b0000) begin
      bad++;
      $display("FAIL midrun_reset: ready=%b done=%b S=%h flags=%b, want 1 0 00 0000",
               b8.ready, b8.done, b8.S, {b8.Co, b8.overflow, b8.zero, b8.negative});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b8.done === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL midrun_nodone: got %0d pulses, want 0", dones);
    end
    b8.A     = 8'h03;
    b8.B     = 8'h04;
    b8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b8.start = 1'b0;
    cyc = 0;
    while (b8.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (b8.done !== 1'b1 || b8.S !== 8'h07) begin
      bad++;
      $display("FAIL post_reset_add: done=%b S=%h, want done=1 S=07", b8.done, b8.S);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_wide();
    logic [15:0] a, b, exp_s;
    logic        o, ci, co, ov;
    logic [16:0] full;
    logic [3:0]  exp_f;
    int          cyc;
    a  = 16'($urandom);
    b  = 16'($urandom);
    o  = 1'($urandom_range(0, 1));
    ci = 1'($urandom_range(0, 1));
    b16.A     = a;
    b16.B     = b;
    b16.op    = o;
    b16.Ci    = ci;
    b16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      if (o == 1'b0) begin
        full  = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
        exp_s = full[15:0];
        co    = full[16];
        ov    = (a[15] == b[15]) && (exp_s[15] != a[15]);
      end else begin
        exp_s = a - b;
        co    = (a >= b);
        ov    = (a[15] != b[15]) && (exp_s[15] != a[15]);
      end
      exp_f = {co, ov, (exp_s == 16'h0000), exp_s[15]};
      while (b16.done !== 1'b1 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      total++;
      if (b16.done !== 1'b1) begin
        bad++;
        $display("FAIL wide%0d_timeout: no done within %0d cycles", i, cyc);
        break;
      end
      if (cyc !== ((i == 0) ? 16 : 18)) begin
        bad++;
        $display("FAIL wide%0d_timing: got %0d cycles, want %0d", i, cyc, (i == 0) ? 16 : 18);
      end
      total++;
      if (b16.S !== exp_s) begin
        bad++;
        $display("FAIL wide%0d_S: op=%b A=%h B=%h Ci=%b got %h, want %h", i, o, a, b, ci, b16.S, exp_s);
      end
      total++;
      if ({b16.Co, b16.overflow, b16.zero, b16.negative} !== exp_f) begin
        bad++;
        $display("FAIL wide%0d_flags: op=%b A=%h B=%h Ci=%b got %b, want %b", i, o, a, b, ci,
                 {b16.Co, b16.overflow, b16.zero, b16.negative}, exp_f);
      end
      // next operands are presented during DONE and taken on the next accept
      a  = 16'($urandom);
      b  = 16'($urandom);
      o  = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      b16.A  = a;
      b16.B  = b;
      b16.op = o;
      b16.Ci = ci;
      if (i == 999) b16.start = 1'b0;
      @(negedge clk);
      cyc = 1;
    end
    b16.start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    b8.start  = 1'b0;
    b8.op     = 1'b0;
    b8.A      = '0;
    b8.B      = '0;
    b8.Ci     = 1'b0;
    b16.start = 1'b0;
    b16.op    = 1'b0;
    b16.A     = '0;
    b16.B     = '0;
    b16.Ci    = 1'b0;
    test_reset();
    test_arith();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
